// File: rtl/ex_iter_ctrl_if.sv
// rtl/ex_iter_ctrl_if.sv - operand, selector, datapath-step and result signals of the e^x iteration sequencer
interface ex_iter_ctrl_if #(
    parameter int DATA_W = 15,
    parameter int IDX_W  = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] sel_data;
    logic [IDX_W-1:0]  sel_i;
    logic              dp_step;
    logic [IDX_W-1:0]  dp_iter;
    logic              dp_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_iter;
    logic              out_err;

    // Environment side: operand source, int_sel, shift/add datapath, result sink
    modport master (
        output in_valid, in_data, sel_i, dp_ack, out_ready,
        input  in_ready, sel_data, dp_step, dp_iter, out_valid, out_data, out_iter, out_err
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_data, sel_i, dp_ack, out_ready,
        output in_ready, sel_data, dp_step, dp_iter, out_valid, out_data, out_iter, out_err
    );
endinterface

// File: rtl/ex_iter_ctrl.sv
// rtl/ex_iter_ctrl.sv - e^x iteration sequencer; optional step watchdog under EX_ITER_TIMEOUT_EN
module ex_iter_ctrl #(
    parameter int DATA_W   = 15,
    parameter int IDX_W    = 5,
    parameter int MAX_ITER = 11
`ifdef EX_ITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    ex_iter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] MAX_N = IDX_W'(MAX_ITER);
    localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

    state_t            state;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  n_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              err_q;
    logic              in_ready_q;
    logic              dp_step_q;
    logic              out_valid_q;

`ifdef EX_ITER_TIMEOUT_EN
    // The stall that would bring the watchdog to all-ones is the one that times out
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] wd_q;
`endif

    // Sequencer FSM with all handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            data_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            dp_step_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef EX_ITER_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        data_q     <= bus.in_data;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= SEL;
                    end
                end
                SEL: begin
                    // int_sel has had a full cycle to settle on the latched operand
                    if (bus.sel_i == '0 || bus.sel_i > MAX_N) begin
                        n_q   <= MAX_N;
                        err_q <= 1'b1;
                    end else begin
                        n_q <= bus.sel_i;
                    end
                    cnt_q     <= ONE;
                    dp_step_q <= 1'b1;
`ifdef EX_ITER_TIMEOUT_EN
                    wd_q      <= '0;
`endif
                    state     <= STEP;
                end
                STEP: begin
                    if (bus.dp_ack) begin
`ifdef EX_ITER_TIMEOUT_EN
                        wd_q <= '0;
`endif
                        if (cnt_q == n_q) begin
                            dp_step_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
`ifdef EX_ITER_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        // Report only the steps the datapath actually completed
                        dp_step_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        n_q         <= cnt_q - ONE;
                        state       <= DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sel_data  = data_q;
    assign bus.dp_step   = dp_step_q;
    assign bus.dp_iter   = cnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_iter  = n_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_ex_iter_ctrl.sv
// tb/tb_ex_iter_ctrl.sv - directed scoreboard bench for ex_iter_ctrl
module tb_ex_iter_ctrl;
    localparam int DATA_W   = 15;
    localparam int IDX_W    = 5;
    localparam int MAX_ITER = 11;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  iter;
        logic              err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  sel_val;
    logic              dp_ack;
    logic              out_ready;

    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   fail_cnt  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_iter_ctrl_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.sel_i     = sel_val;
    assign bus.dp_ack    = dp_ack;
    assign bus.out_ready = out_ready;

    ex_iter_ctrl #(.DATA_W(DATA_W), .IDX_W(IDX_W), .MAX_ITER(MAX_ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one operand; returns the step count the sequencer should use
    task automatic accept(input logic [DATA_W-1:0] data, input logic [IDX_W-1:0] sel, output int n);
        int   t;
        exp_t e;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        chk("accept_ready", bus.in_ready, 1);
        in_data  = data;
        sel_val  = sel;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sel_data", bus.sel_data, data);
        chk("in_ready_busy", bus.in_ready, 0);
        n      = (sel == 0 || sel > MAX_ITER) ? MAX_ITER : int'(sel);
        e.data = data;
        e.iter = IDX_W'(n);
        e.err  = (sel == 0 || sel > MAX_ITER);
        sb.push_back(e);
    endtask

    // From cycle 1 with dp_ack high: steps in cycles 2..n+1, out_valid in n+2
    task automatic run_steps(input int n);
        for (int c = 1; c <= n + 2; c++) begin
            chk($sformatf("dp_step_c%0d", c), bus.dp_step, (c >= 2 && c <= n + 1));
            if (c >= 2 && c <= n + 1)
                chk($sformatf("dp_iter_c%0d", c), bus.dp_iter, c - 1);
            chk($sformatf("out_valid_c%0d", c), bus.out_valid, (c == n + 2));
            if (c < n + 2) tick();
        end
    endtask

    // Hold back out_ready, then complete the result handshake against the scoreboard
    task automatic finish_out(input int hold);
        logic [DATA_W-1:0] d0;
        logic [IDX_W-1:0]  i0;
        logic              e0;
        exp_t              e;
        d0 = bus.out_data;
        i0 = bus.out_iter;
        e0 = bus.out_err;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, d0);
            chk("hold_iter", bus.out_iter, i0);
            chk("hold_err", bus.out_err, e0);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid", bus.out_valid, 1);
            chk("out_data", bus.out_data, e.data);
            chk("out_iter", bus.out_iter, e.iter);
            chk("out_err", bus.out_err, e.err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", bus.out_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        int n;
        int cyc;
        int stall_ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        sel_val   = '0;
        dp_ack    = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_dp_step", bus.dp_step, 0);
        chk("rst_dp_iter", bus.dp_iter, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_iter", bus.out_iter, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_sel_data", bus.sel_data, 0);
        rst = 1'b0;
        tick();

        // Single step
        accept(15'h0400, 5'd1, n);
        run_steps(n);
        finish_out(0);

        // Full count
        accept(15'h0001, 5'd11, n);
        run_steps(n);
        finish_out(0);

        // Clamped indices
        accept(15'h2222, 5'd0, n);
        run_steps(n);
        finish_out(0);
        accept(15'h3333, 5'd20, n);
        run_steps(n);
        finish_out(0);

        // Output backpressure, then an immediate next operand
        accept(15'h1234, 5'd3, n);
        run_steps(n);
        finish_out(5);
        accept(15'h0567, 5'd2, n);
        run_steps(n);
        finish_out(0);

        // Reset during step 4 of 9
        accept(15'h0abc, 5'd9, n);
        repeat (4) tick();
        chk("pre_rst_iter", bus.dp_iter, 4);
        chk("pre_rst_step", bus.dp_step, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_step", bus.dp_step, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        chk("after_rst_step", bus.dp_step, 0);
        accept(15'h0def, 5'd9, n);
        run_steps(n);
        finish_out(0);

        // Stalled datapath
        dp_ack = 1'b0;
        accept(15'h0055, 5'd5, n);
        tick();
        chk("stall_step", bus.dp_step, 1);
        chk("stall_iter", bus.dp_iter, 1);
`ifdef EX_ITER_TIMEOUT_EN
        begin
            exp_t e;
            e = sb.pop_back();
            e.iter = '0;
            e.err  = 1'b1;
            sb.push_back(e);
        end
        cyc = 2;
        while (bus.out_valid !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("timeout_cycle", cyc, 257);
        chk("timeout_step", bus.dp_step, 0);
        finish_out(0);
`else
        stall_ok = 1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (bus.dp_step !== 1'b1 || bus.out_valid !== 1'b0) stall_ok = 0;
        end
        chk("stall_1000", stall_ok, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        chk("stall_rst_step", bus.dp_step, 0);
`endif
        dp_ack = 1'b1;
        accept(15'h0077, 5'd4, n);
        run_steps(n);
        finish_out(0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
